// File: rtl/alu_seq_if.sv
// Handshake bundle linking the operand-issue stage, the sequential ALU
// and the writeback consumer.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opc;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             overflow;

    // Issue/writeback side: offers operations and consumes results
    modport master (
        output in_valid, opc, A, B, out_ready,
        input  in_ready, out_valid, result, carry, zero, overflow
    );

    // ALU side
    modport slave (
        input  in_valid, opc, A, B, out_ready,
        output in_ready, out_valid, result, carry, zero, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with a registered result behind a valid/ready handshake.
// Single-cycle ops finish one edge after accept; shifts by a non-zero amount
// walk a working register one bit per cycle in the SHIFT state.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       sh_op_q, sh_op_d;
    logic             sign_q, sign_d;

    logic             in_ready;
    logic             accept;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;
    logic             sltu_bit;
    logic             eq_bit;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_ovf;
    logic             is_shift;
    logic [SHW-1:0]   shamt_raw;
    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] shreg_next;

    // Ready only when idle, out of reset, and the output register is free or draining
    assign in_ready  = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign shamt_raw = bus.B[SHW-1:0];
    assign is_shift  = (bus.opc == OP_SLL) || (bus.opc == OP_SRL) || (bus.opc == OP_SRA);

    // Single-cycle datapath evaluated on the live operands; only used at accept
    always_comb begin
        add_full   = {1'b0, bus.A} + {1'b0, bus.B};
        sub_full   = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);
        add_ovf    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_full[WIDTH-1] != bus.A[WIDTH-1]);
        sub_ovf    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_full[WIDTH-1] != bus.A[WIDTH-1]);
        slt_bit    = sub_full[WIDTH-1] ^ sub_ovf;
        sltu_bit   = ~sub_full[WIDTH];
        eq_bit     = (bus.A == bus.B);
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (bus.opc)
            OP_ADD: begin
                alu_result = add_full[WIDTH-1:0];
                alu_carry  = add_full[WIDTH];
                alu_ovf    = add_ovf;
            end
            OP_SUB: begin
                alu_result = sub_full[WIDTH-1:0];
                alu_carry  = sub_full[WIDTH];
                alu_ovf    = sub_ovf;
            end
            OP_NOT:  alu_result = ~bus.A;
            OP_AND:  alu_result = bus.A & bus.B;
            OP_OR:   alu_result = bus.A | bus.B;
            OP_XOR:  alu_result = bus.A ^ bus.B;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_EQ:   alu_result = {{(WIDTH-1){1'b0}}, eq_bit};
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, sltu_bit};
            OP_SLL, OP_SRL, OP_SRA: alu_result = bus.A;
            default: alu_result = '0;
        endcase
    end

    // Clamp the shift amount so oversize shifts saturate at WIDTH steps
    always_comb begin
        shamt = CW'(shamt_raw);
        if (shamt > CW'(WIDTH)) begin
            shamt = CW'(WIDTH);
        end
    end

    // One-bit step of the working register; SRA refills with the captured sign
    always_comb begin
        shreg_next = shreg_q;
        case (sh_op_q)
            2'b01:   shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
            2'b10:   shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
            default: shreg_next = {sign_q, shreg_q[WIDTH-1:1]};
        endcase
    end

    // Next-state logic for the FSM, the output register and the shift engine
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        sh_op_d     = sh_op_q;
        sign_d      = sign_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d = SHIFT;
                        shreg_d = bus.A;
                        cnt_d   = shamt;
                        sh_op_d = bus.opc[1:0];
                        sign_d  = bus.A[WIDTH-1];
                    end else begin
                        result_d    = alu_result;
                        carry_d     = alu_carry;
                        overflow_d  = alu_ovf;
                        zero_d      = (alu_result == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shreg_next;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = IDLE;
                    result_d    = shreg_next;
                    carry_d     = 1'b0;
                    overflow_d  = 1'b0;
                    zero_d      = (shreg_next == '0);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            sh_op_q     <= 2'b00;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            sh_op_q     <= sh_op_d;
            sign_q      <= sign_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 4-bit combinational ALU.
- Keeps the original opcodes 0-7, widens opc to 4 bits, adds SLTU and iterative shifts, and registers the result behind a valid/ready interface.
- Sits between an operand-issue stage and a writeback consumer; either side may stall.

Parameters:
- WIDTH, 4, operand/result width in bits; legal values are WIDTH >= 2.
- SHW, $clog2(WIDTH), localparam giving the shift-amount width (B[SHW-1:0]).

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- opc  in  4  operation code.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; for shifts, B[SHW-1:0] is the shift amount.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- carry  out  1  carry flag.
- zero  out  1  zero flag.
- overflow  out  1  signed-overflow flag.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, out_valid=0, result=0, carry=0, zero=0, overflow=0. in_ready is 0 during reset.
- Reset mid-shift or mid-stall aborts the operation; the result is lost.
- Opcodes:
  - 0000 ADD: A+B.
  - 0001 SUB: A+~B+1.
  - 0010 NOT: ~A.
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
  - 0110 SLT: signed A<B, computed as sub_result[MSB]^sub_overflow; result is zero-extended 1 bit.
  - 0111 EQ: result is zero-extended (A==B).
  - 1000 SLTU: result is zero-extended unsigned A<B, which equals ~sub_carry.
  - 1001 SLL, 1010 SRL, 1011 SRA.
  - 1100-1111 reserved: result=0, zero=1, carry=0, overflow=0, single-cycle.
- Flags:
  - carry: ADD gives the carry-out; SUB gives the carry-out of A+~B+1 (1 means no borrow). 0 for all other ops.
  - overflow: signed overflow for ADD/SUB only, else 0.
  - zero: (result==0) for every opcode, including reserved.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). A drain and a new accept in the same cycle are allowed, giving full throughput.
  - A, B and opc are captured at accept; later input changes are ignored.
  - While out_valid && !out_ready, result and flags hold stable and out_valid stays 1.
  - out_valid falls the cycle after out_ready is sampled high, unless a new result loads in that cycle.
- FSM (IDLE, SHIFT):
  - IDLE, accepting a non-shift op, or a shift with shamt==0: the result registers at that edge and out_valid=1 on the next cycle (latency 1).
  - IDLE, accepting a shift with shamt>0: load the working register with A and counter=min(shamt,WIDTH), then go to SHIFT. in_ready=0 while in SHIFT.
  - SHIFT: each cycle the register shifts one bit and the counter decrements.
    - SLL/SRL fill with 0.
    - SRA fills with the captured A[MSB].
  - When the counter reaches 1, that edge writes result/flags, sets out_valid=1 and returns to IDLE. Latency is min(shamt,WIDTH) cycles after accept.
  - SHIFT cannot complete while an older result is still stalled: in_ready already required the output register to be free or draining at accept.
- shamt >= WIDTH (only possible for non-power-of-two WIDTH): SLL/SRL give 0; SRA gives all copies of the sign bit.
- Arithmetic wraps modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=4, ADD A=0111 B=0001, out_ready=1 -> next cycle out_valid=1, result=1000, carry=0, overflow=1, zero=0.
- WIDTH=4, SUB A=0011 B=0101 -> result=1110, carry=0, overflow=0. Then SLT on the same operands -> 0001. SLTU A=1000 B=0001 -> 0000.
- WIDTH=8, SRA A=0x90 B=3 -> in_ready=0 for 3 cycles, result=0xF2 three cycles after accept. SLL A=0x81 B=0 -> result=0x81 with latency 1.
- Backpressure: out_ready=0 for 4 cycles after an AND result -> result/flags constant and in_ready=0. On the cycle out_ready=1 with in_valid=1, the new op is accepted and its result appears the next cycle.
- Back-to-back: 8 single-cycle ops with in_valid and out_ready held at 1 -> one result per cycle, in order, no bubbles. EQ A=B=0xA -> result=0001, zero=0.
- rst_n=0 for one cycle during SHIFT (WIDTH=8, SRL B=7, after 3 cycles) -> next cycle out_valid=0, result=0, flags=0, in_ready=1 once rst_n=1. Reserved opc 1110 -> result=0, zero=1.
